mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 op  in  6  instruction[31:26], taken from the instruction register output.
REQ-005 funct  in  6  instruction[5:0].
REQ-006 zero  in  1  ALU result-equals-zero flag.
REQ-007 im_ready  in  1  instruction memory data valid; used only with IM_WAIT_EN.
REQ-008 pcwr  out  1  PC write enable.
REQ-009 irwr  out  1  instruction register write enable.
REQ-010 regwr  out  1  register file write enable.
REQ-011 dmwr  out  1  data memory write enable.
REQ-012 npc_sel  out  2  next-PC source: 00 PC+4, 01 branch target, 10 jump target.
REQ-013 alu_op  out  2  ALU operation: 00 add, 01 sub, 10 or, 11 lui (imm<<16).
REQ-014 alusrc  out  1  ALU B operand: 0 register rt, 1 extended immediate.
REQ-015 ext_op  out  1  immediate extension: 0 zero-extend, 1 sign-extend.
REQ-016 reg_dst  out  1  write register: 0 rt, 1 rd.
REQ-017 wd_sel  out  1  register write data: 0 ALU result, 1 data memory.
REQ-018 state  out  3  current state: FETCH=0, DCD=1, EXE=2, MEM=3, WB=4.
REQ-019 ill  out  1  one-cycle pulse on an undecodable instruction.

Function
REQ-020 The block SHALL decode the following instructions:
- addu: op 000000, funct 100001
- subu: op 000000, funct 100011
- ori: op 001101
- lui: op 001111
- lw: op 100011
- sw: op 101011
- beq: op 000100
- j: op 000010
REQ-021 Any other op/funct combination SHALL be illegal.
REQ-022 FETCH SHALL assert irwr=1, pcwr=1 and npc_sel=00, then go to DCD.
REQ-023 op and funct SHALL be sampled only in DCD, EXE, MEM and WB.
REQ-024 DCD with j SHALL assert pcwr=1, npc_sel=10 and go to FETCH (2 cycles total).
REQ-025 DCD with an illegal instruction SHALL pulse ill=1, assert no write enable, and go to FETCH.
REQ-026 DCD with any other legal instruction SHALL go to EXE.
REQ-027 EXE alu_op SHALL be: addu/lw/sw 00; subu/beq 01; ori 10; lui 11.
REQ-028 EXE alusrc SHALL be 1 for ori/lui/lw/sw and 0 otherwise.
REQ-029 ext_op SHALL be 1 for lw/sw/beq and 0 otherwise.
REQ-030 EXE for beq SHALL assert pcwr=zero, npc_sel=01 and go to FETCH (3 cycles total).
REQ-031 EXE SHALL go to MEM for lw/sw and to WB for addu/subu/ori/lui.
REQ-032 MEM for sw SHALL assert dmwr=1 and go to FETCH (4 cycles total).
REQ-033 MEM for lw SHALL go to WB.
REQ-034 WB SHALL assert regwr=1 and go to FETCH; lw takes 5 cycles total, R-type/ori/lui take 4.
REQ-035 WB reg_dst SHALL be 1 for addu/subu, else 0.
REQ-036 WB wd_sel SHALL be 1 for lw, else 0.
REQ-037 Each write enable SHALL be high for exactly one cycle per instruction, in its stated state only.
REQ-038 Outside the states and conditions above, all write enables SHALL be 0, npc_sel 00 and alu_op 00.
REQ-039 Any unreachable state encoding SHALL go to FETCH on the next edge with all enables 0.

Reset
REQ-040 While rst=0, state SHALL be FETCH, and pcwr, irwr, regwr, dmwr and ill SHALL be 0.
REQ-041 While rst=0, npc_sel, alu_op, alusrc, ext_op, reg_dst and wd_sel SHALL be 0.
REQ-042 Assertion of rst in any state, including mid-instruction, SHALL abort that instruction with no further write enable.
REQ-043 The first rising edge after rst deasserts SHALL be a FETCH cycle with irwr=1 and pcwr=1.

Configuration
REQ-044 With macro IM_WAIT_EN defined, FETCH SHALL hold with irwr=0 and pcwr=0 while im_ready=0.
REQ-045 With IM_WAIT_EN defined, FETCH SHALL assert irwr=1 and pcwr=1 and go to DCD in the first cycle im_ready=1.
REQ-046 Without IM_WAIT_EN, the im_ready port SHALL exist but be ignored, and FETCH SHALL always last one cycle.

Verification
REQ-047 Reset release, then addu (op 000000, funct 100001) -> state 0,1,2,4,0; regwr=1 and reg_dst=1 in cycle 4 only.
REQ-048 lw (op 100011) -> states 0,1,2,3,4; alusrc=1, ext_op=1 in EXE; regwr=1, wd_sel=1 in WB.
REQ-049 sw -> dmwr=1 in MEM only, regwr never 1; beq with zero=1 -> pcwr=1, npc_sel=01 in EXE.
REQ-050 beq with zero=0 -> pcwr stays 0 in EXE.
REQ-051 j -> pcwr=1, npc_sel=10 in DCD; op 111111 -> ill=1 for one cycle, then FETCH.
REQ-052 Apply rst=0 in MEM of sw -> dmwr=0 immediately, state 0 while reset is held.
REQ-053 With IM_WAIT_EN, im_ready=0 for 3 cycles -> irwr low for 3 cycles, then high for 1 cycle.

Source files
------------

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS-subset control unit.
//
// Sequences each instruction through FETCH -> DCD -> EXE -> MEM -> WB, taking
// only the states the instruction needs, and drives the datapath
// enables/selects for the current state.
//
// Supported instructions: addu, subu, ori, lui, lw, sw, beq, j. Any other
// op/funct pulses ill in DCD and returns to FETCH.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous, active-low reset
//   op        in   [5:0] instruction[31:26] from the instruction register
//   funct     in   [5:0] instruction[5:0]
//   zero      in   ALU result-equals-zero flag (beq condition)
//   im_ready  in   instruction memory data valid (IM_WAIT_EN builds only)
//   pcwr      out  PC write enable
//   irwr      out  instruction register write enable
//   regwr     out  register file write enable
//   dmwr      out  data memory write enable
//   npc_sel   out  [1:0] next PC: 00 PC+4, 01 branch target, 10 jump target
//   alu_op    out  [1:0] 00 add, 01 sub, 10 or, 11 lui
//   alusrc    out  ALU B operand: 0 rt, 1 extended immediate
//   ext_op    out  immediate extension: 0 zero, 1 sign
//   reg_dst   out  write register: 0 rt, 1 rd
//   wd_sel    out  write data: 0 ALU result, 1 data memory
//   state     out  [2:0] FETCH=0, DCD=1, EXE=2, MEM=3, WB=4
//   ill       out  one-cycle pulse on an undecodable instruction
//
// Build option: define IM_WAIT_EN to stall FETCH until im_ready=1.
module mc_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       im_ready,
  output logic       pcwr,
  output logic       irwr,
  output logic       regwr,
  output logic       dmwr,
  output logic [1:0] npc_sel,
  output logic [1:0] alu_op,
  output logic       alusrc,
  output logic       ext_op,
  output logic       reg_dst,
  output logic       wd_sel,
  output logic [2:0] state,
  output logic       ill
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_DCD   = 3'd1,
    S_EXE   = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic is_addu, is_subu, is_ori, is_lui, is_lw, is_sw, is_beq, is_j;
  logic is_legal, dec_ext;

`ifndef IM_WAIT_EN
  logic unused_im_ready;
  assign unused_im_ready = im_ready;
`endif

  always_comb begin
    is_addu  = (op == 6'b000000) && (funct == 6'b100001);
    is_subu  = (op == 6'b000000) && (funct == 6'b100011);
    is_ori   = (op == 6'b001101);
    is_lui   = (op == 6'b001111);
    is_lw    = (op == 6'b100011);
    is_sw    = (op == 6'b101011);
    is_beq   = (op == 6'b000100);
    is_j     = (op == 6'b000010);
    is_legal = is_addu | is_subu | is_ori | is_lui | is_lw | is_sw | is_beq | is_j;
    dec_ext  = is_lw | is_sw | is_beq;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  assign state = state_q;

  // Outputs are combinational from state and decode; gating with rst makes
  // a mid-instruction reset kill any pending enable immediately.
  always_comb begin
    state_d = S_FETCH;
    pcwr    = 1'b0;
    irwr    = 1'b0;
    regwr   = 1'b0;
    dmwr    = 1'b0;
    npc_sel = 2'b00;
    alu_op  = 2'b00;
    alusrc  = 1'b0;
    ext_op  = 1'b0;
    reg_dst = 1'b0;
    wd_sel  = 1'b0;
    ill     = 1'b0;
    if (rst) begin
      case (state_q)
        S_FETCH: begin
`ifdef IM_WAIT_EN
          if (im_ready) begin
            irwr    = 1'b1;
            pcwr    = 1'b1;
            state_d = S_DCD;
          end else begin
            state_d = S_FETCH;
          end
`else
          irwr    = 1'b1;
          pcwr    = 1'b1;
          state_d = S_DCD;
`endif
        end
        S_DCD: begin
          ext_op = dec_ext;
          if (is_j) begin
            pcwr    = 1'b1;
            npc_sel = 2'b10;
            state_d = S_FETCH;
          end else if (!is_legal) begin
            ill     = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_EXE;
          end
        end
        S_EXE: begin
          ext_op = dec_ext;
          alusrc = is_ori | is_lui | is_lw | is_sw;
          if (is_subu || is_beq) alu_op = 2'b01;
          else if (is_ori)       alu_op = 2'b10;
          else if (is_lui)       alu_op = 2'b11;
          if (is_beq) begin
            pcwr    = zero;
            npc_sel = 2'b01;
            state_d = S_FETCH;
          end else if (is_lw || is_sw) begin
            state_d = S_MEM;
          end else if (is_addu || is_subu || is_ori || is_lui) begin
            state_d = S_WB;
          end
        end
        S_MEM: begin
          ext_op = dec_ext;
          if (is_sw) begin
            dmwr    = 1'b1;
            state_d = S_FETCH;
          end else if (is_lw) begin
            state_d = S_WB;
          end
        end
        S_WB: begin
          ext_op  = dec_ext;
          regwr   = 1'b1;
          reg_dst = is_addu | is_subu;
          wd_sel  = is_lw;
          state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed-vector bench for mc_ctrl. Each cycle the full output bundle is
// compared against a hand-built expected vector.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       im_ready = 1'b1;
  logic       pcwr, irwr, regwr, dmwr, alusrc, ext_op, reg_dst, wd_sel, ill;
  logic [1:0] npc_sel, alu_op;
  logic [2:0] state;

  int n_vec = 0;
  int n_err = 0;

  mc_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .im_ready(im_ready),
    .pcwr(pcwr), .irwr(irwr), .regwr(regwr), .dmwr(dmwr), .npc_sel(npc_sel),
    .alu_op(alu_op), .alusrc(alusrc), .ext_op(ext_op), .reg_dst(reg_dst),
    .wd_sel(wd_sel), .state(state), .ill(ill)
  );

  always #5 clk = ~clk;

  logic [15:0] obs;
  assign obs = {state, pcwr, irwr, regwr, dmwr, npc_sel, alu_op, alusrc, ext_op, reg_dst, wd_sel, ill};

  // Field order: state, pcwr, irwr, regwr, dmwr, npc_sel, alu_op, alusrc, ext_op, reg_dst, wd_sel, ill
  function automatic logic [15:0] ev(input logic [2:0] st, input logic pw, iw, rw, dw,
                                     input logic [1:0] npc, alu, input logic asrc, ext, rd, wd, il);
    return {st, pw, iw, rw, dw, npc, alu, asrc, ext, rd, wd, il};
  endfunction

  task automatic test_reset();
    logic [15:0] exp_z, exp_f;
    exp_z = ev(0,0,0,0,0,0,0,0,0,0,0,0);
    exp_f = ev(0,1,1,0,0,0,0,0,0,0,0,0);
    rst = 1'b0; op = 6'b000010; funct = 6'd0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1; n_vec++;
      if (obs !== exp_z) begin
        n_err++; $display("FAIL reset_hold cyc%0d got=%h want=%h", i, obs, exp_z);
      end
      @(negedge clk);
    end
    rst = 1'b1;
    #1; n_vec++;
    if (obs !== exp_f) begin
      n_err++; $display("FAIL reset_release got=%h want=%h", obs, exp_f);
    end
  endtask

  task automatic test_alu_ops();
    logic [5:0]  ops [4];
    logic [5:0]  fns [4];
    logic [15:0] seq [4];
    logic [15:0] exe [4];
    logic [15:0] wb  [4];
    ops = '{6'b000000, 6'b000000, 6'b001101, 6'b001111};
    fns = '{6'b100001, 6'b100011, 6'b000000, 6'b000000};
    exe = '{ev(2,0,0,0,0,0,0,0,0,0,0,0), ev(2,0,0,0,0,0,1,0,0,0,0,0),
            ev(2,0,0,0,0,0,2,1,0,0,0,0), ev(2,0,0,0,0,0,3,1,0,0,0,0)};
    wb  = '{ev(4,0,0,1,0,0,0,0,0,1,0,0), ev(4,0,0,1,0,0,0,0,0,1,0,0),
            ev(4,0,0,1,0,0,0,0,0,0,0,0), ev(4,0,0,1,0,0,0,0,0,0,0,0)};
    for (int k = 0; k < 4; k++) begin
      op = ops[k]; funct = fns[k];
      seq = '{ev(0,1,1,0,0,0,0,0,0,0,0,0), ev(1,0,0,0,0,0,0,0,0,0,0,0), exe[k], wb[k]};
      for (int i = 0; i < 4; i++) begin
        #1; n_vec++;
        if (obs !== seq[i]) begin
          n_err++; $display("FAIL alu_op%0d cyc%0d got=%h want=%h", k, i, obs, seq[i]);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_lw();
    logic [15:0] seq [5];
    seq = '{ev(0,1,1,0,0,0,0,0,0,0,0,0), ev(1,0,0,0,0,0,0,0,1,0,0,0),
            ev(2,0,0,0,0,0,0,1,1,0,0,0), ev(3,0,0,0,0,0,0,0,1,0,0,0),
            ev(4,0,0,1,0,0,0,0,1,0,1,0)};
    op = 6'b100011; funct = 6'b111111;
    for (int i = 0; i < 5; i++) begin
      #1; n_vec++;
      if (obs !== seq[i]) begin
        n_err++; $display("FAIL lw cyc%0d got=%h want=%h", i, obs, seq[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_sw();
    logic [15:0] seq [4];
    seq = '{ev(0,1,1,0,0,0,0,0,0,0,0,0), ev(1,0,0,0,0,0,0,0,1,0,0,0),
            ev(2,0,0,0,0,0,0,1,1,0,0,0), ev(3,0,0,0,1,0,0,0,1,0,0,0)};
    op = 6'b101011; funct = 6'd0;
    for (int i = 0; i < 4; i++) begin
      #1; n_vec++;
      if (obs !== seq[i]) begin
        n_err++; $display("FAIL sw cyc%0d got=%h want=%h", i, obs, seq[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_beq();
    logic [15:0] seq [3];
    for (int z = 1; z >= 0; z--) begin
      zero = z[0];
      op = 6'b000100; funct = 6'd0;
      seq = '{ev(0,1,1,0,0,0,0,0,0,0,0,0), ev(1,0,0,0,0,0,0,0,1,0,0,0),
              ev(2,z[0],0,0,0,1,1,0,1,0,0,0)};
      for (int i = 0; i < 3; i++) begin
        #1; n_vec++;
        if (obs !== seq[i]) begin
          n_err++; $display("FAIL beq_zero%0d cyc%0d got=%h want=%h", z, i, obs, seq[i]);
        end
        @(negedge clk);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_jump_illegal();
    logic [5:0]  ops [3];
    logic [5:0]  fns [3];
    logic [15:0] dcd [3];
    logic [15:0] seq [2];
    ops = '{6'b000010, 6'b111111, 6'b000000};
    fns = '{6'b000000, 6'b000000, 6'b100000};
    dcd = '{ev(1,1,0,0,0,2,0,0,0,0,0,0), ev(1,0,0,0,0,0,0,0,0,0,0,1),
            ev(1,0,0,0,0,0,0,0,0,0,0,1)};
    for (int k = 0; k < 3; k++) begin
      op = ops[k]; funct = fns[k];
      seq = '{ev(0,1,1,0,0,0,0,0,0,0,0,0), dcd[k]};
      for (int i = 0; i < 2; i++) begin
        #1; n_vec++;
        if (obs !== seq[i]) begin
          n_err++; $display("FAIL j_ill%0d cyc%0d got=%h want=%h", k, i, obs, seq[i]);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_fetch_wait();
    logic [15:0] exp_f, exp_j;
    exp_f = ev(0,1,1,0,0,0,0,0,0,0,0,0);
    exp_j = ev(1,1,0,0,0,2,0,0,0,0,0,0);
    op = 6'b000010; funct = 6'd0;
    im_ready = 1'b0;
`ifdef IM_WAIT_EN
    for (int i = 0; i < 3; i++) begin
      #1; n_vec++;
      if (obs !== ev(0,0,0,0,0,0,0,0,0,0,0,0)) begin
        n_err++; $display("FAIL fetch_stall cyc%0d got=%h want=%h", i, obs, ev(0,0,0,0,0,0,0,0,0,0,0,0));
      end
      @(negedge clk);
    end
    im_ready = 1'b1;
`endif
    #1; n_vec++;
    if (obs !== exp_f) begin
      n_err++; $display("FAIL fetch_go got=%h want=%h", obs, exp_f);
    end
    @(negedge clk);
    im_ready = 1'b1;
    #1; n_vec++;
    if (obs !== exp_j) begin
      n_err++; $display("FAIL fetch_then_dcd got=%h want=%h", obs, exp_j);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    logic [15:0] seq [4];
    logic [15:0] exp_z;
    exp_z = ev(0,0,0,0,0,0,0,0,0,0,0,0);
    seq = '{ev(0,1,1,0,0,0,0,0,0,0,0,0), ev(1,0,0,0,0,0,0,0,1,0,0,0),
            ev(2,0,0,0,0,0,0,1,1,0,0,0), ev(3,0,0,0,1,0,0,0,1,0,0,0)};
    op = 6'b101011; funct = 6'd0;
    for (int i = 0; i < 4; i++) begin
      #1; n_vec++;
      if (obs !== seq[i]) begin
        n_err++; $display("FAIL abort_pre cyc%0d got=%h want=%h", i, obs, seq[i]);
      end
      if (i < 3) @(negedge clk);
    end
    rst = 1'b0;
    #1; n_vec++;
    if (obs !== exp_z) begin
      n_err++; $display("FAIL abort_now got=%h want=%h", obs, exp_z);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1; n_vec++;
      if (obs !== exp_z) begin
        n_err++; $display("FAIL abort_hold cyc%0d got=%h want=%h", i, obs, exp_z);
      end
    end
    rst = 1'b1;
    #1; n_vec++;
    if (obs !== seq[0]) begin
      n_err++; $display("FAIL abort_release got=%h want=%h", obs, seq[0]);
    end
    @(negedge clk); #1; n_vec++;
    if (obs !== seq[1]) begin
      n_err++; $display("FAIL abort_restart got=%h want=%h", obs, seq[1]);
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_lw();
    test_sw();
    test_beq();
    test_jump_illegal();
    test_fetch_wait();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
